// File: rtl/phaser_out_tap_ctrl.sv
// phaser_out_tap_ctrl
//   Walks a PHASER_OUT coarse/fine delay line from its current tap position to a
//   requested (coarse, fine) target. It issues one single-cycle enable pulse per tap
//   step and waits STEP_GAP cycles after every pulse so the phaser can settle. Coarse
//   steps always finish before fine steps. An overflow flag seen during a settle gap
//   aborts the walk and sets a sticky ERR flag.
//
//   Ports
//     SYSCLK, RST_N                 clock, synchronous active-low reset
//     REQ_VALID/REQ_READY           request handshake; READY is high only when idle
//     REQ_COARSE, REQ_FINE          6-bit target taps
//     DONE                          one-cycle pulse on completion or abort
//     ERR                           sticky overflow abort, cleared by the next accept
//     BUSY                          high whenever a request is being processed
//     CUR_COARSE, CUR_FINE          tracked phaser position
//     COARSEENABLE/COARSEINC        coarse step pulse and direction (1 = up)
//     FINEENABLE/FINEINC            fine step pulse and direction (1 = up)
//     COARSEOVERFLOW, FINEOVERFLOW  overflow flags from the phaser
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   IDLE   | waiting for a request, READY high
//   C_STEP | one coarse enable pulse, coarse position moves by one
//   C_WAIT | coarse settle gap, watching COARSEOVERFLOW
//   F_STEP | one fine enable pulse, fine position moves by one
//   F_WAIT | fine settle gap, watching FINEOVERFLOW
//   FIN    | DONE pulse, back to IDLE
module phaser_out_tap_ctrl #(
    parameter int STEP_GAP    = 8,
    parameter int COARSE_INIT = 0,
    parameter int FINE_INIT   = 0
) (
    input  logic       SYSCLK,
    input  logic       RST_N,
    input  logic       REQ_VALID,
    output logic       REQ_READY,
    input  logic [5:0] REQ_COARSE,
    input  logic [5:0] REQ_FINE,
    output logic       DONE,
    output logic       ERR,
    output logic       BUSY,
    output logic [5:0] CUR_COARSE,
    output logic [5:0] CUR_FINE,
    output logic       COARSEENABLE,
    output logic       COARSEINC,
    output logic       FINEENABLE,
    output logic       FINEINC,
    input  logic       COARSEOVERFLOW,
    input  logic       FINEOVERFLOW
);

    localparam logic [5:0] C_INIT   = 6'(COARSE_INIT);
    localparam logic [5:0] F_INIT   = 6'(FINE_INIT);
    localparam logic [7:0] GAP_LOAD = 8'(STEP_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_C_STEP,
        S_C_WAIT,
        S_F_STEP,
        S_F_WAIT,
        S_FIN
    } state_t;

    state_t     state, state_d;
    logic [5:0] tgt_coarse, tgt_coarse_d;
    logic [5:0] tgt_fine, tgt_fine_d;
    logic [5:0] cur_coarse_d, cur_fine_d;
    logic [7:0] gap_cnt, gap_cnt_d;
    logic       err_d;
    logic       c_en_d, c_inc_d, f_en_d, f_inc_d;
    logic       done_d, busy_d, ready_d;

    always_comb begin
        state_d      = state;
        tgt_coarse_d = tgt_coarse;
        tgt_fine_d   = tgt_fine;
        cur_coarse_d = CUR_COARSE;
        cur_fine_d   = CUR_FINE;
        gap_cnt_d    = gap_cnt;
        err_d        = ERR;

        case (state)
            S_IDLE: begin
                if (REQ_VALID && REQ_READY) begin
                    tgt_coarse_d = REQ_COARSE;
                    tgt_fine_d   = REQ_FINE;
                    err_d        = 1'b0;
                    if (REQ_COARSE != CUR_COARSE)
                        state_d = S_C_STEP;
                    else if (REQ_FINE != CUR_FINE)
                        state_d = S_F_STEP;
                    else
                        state_d = S_FIN;
                end
            end
            S_C_STEP: begin
                cur_coarse_d = (tgt_coarse > CUR_COARSE) ? CUR_COARSE + 6'd1 : CUR_COARSE - 6'd1;
                gap_cnt_d    = GAP_LOAD;
                state_d      = S_C_WAIT;
            end
            S_C_WAIT: begin
                if (COARSEOVERFLOW) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (gap_cnt == 8'd0) begin
                    if (CUR_COARSE != tgt_coarse)
                        state_d = S_C_STEP;
                    else if (CUR_FINE != tgt_fine)
                        state_d = S_F_STEP;
                    else
                        state_d = S_FIN;
                end else begin
                    gap_cnt_d = gap_cnt - 8'd1;
                end
            end
            S_F_STEP: begin
                cur_fine_d = (tgt_fine > CUR_FINE) ? CUR_FINE + 6'd1 : CUR_FINE - 6'd1;
                gap_cnt_d  = GAP_LOAD;
                state_d    = S_F_WAIT;
            end
            S_F_WAIT: begin
                if (FINEOVERFLOW) begin
                    err_d   = 1'b1;
                    state_d = S_FIN;
                end else if (gap_cnt == 8'd0) begin
                    state_d = (CUR_FINE != tgt_fine) ? S_F_STEP : S_FIN;
                end else begin
                    gap_cnt_d = gap_cnt - 8'd1;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with the
        // state register. The position does not change on entry to a STEP state,
        // so the direction compare against the current position is exact.
        c_en_d  = (state_d == S_C_STEP);
        c_inc_d = c_en_d && (tgt_coarse_d > cur_coarse_d);
        f_en_d  = (state_d == S_F_STEP);
        f_inc_d = f_en_d && (tgt_fine_d > cur_fine_d);
        done_d  = (state_d == S_FIN);
        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            tgt_coarse   <= C_INIT;
            tgt_fine     <= F_INIT;
            CUR_COARSE   <= C_INIT;
            CUR_FINE     <= F_INIT;
            gap_cnt      <= 8'd0;
            ERR          <= 1'b0;
            COARSEENABLE <= 1'b0;
            COARSEINC    <= 1'b0;
            FINEENABLE   <= 1'b0;
            FINEINC      <= 1'b0;
            DONE         <= 1'b0;
            BUSY         <= 1'b0;
            REQ_READY    <= 1'b1;
        end else begin
            state        <= state_d;
            tgt_coarse   <= tgt_coarse_d;
            tgt_fine     <= tgt_fine_d;
            CUR_COARSE   <= cur_coarse_d;
            CUR_FINE     <= cur_fine_d;
            gap_cnt      <= gap_cnt_d;
            ERR          <= err_d;
            COARSEENABLE <= c_en_d;
            COARSEINC    <= c_inc_d;
            FINEENABLE   <= f_en_d;
            FINEINC      <= f_inc_d;
            DONE         <= done_d;
            BUSY         <= busy_d;
            REQ_READY    <= ready_d;
        end
    end

endmodule

// File: tb/tb_phaser_out_tap_ctrl.sv
module tb_phaser_out_tap_ctrl;

    localparam int GAP = 8;

    logic       SYSCLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic [5:0] REQ_COARSE = 6'd0;
    logic [5:0] REQ_FINE = 6'd0;
    logic       DONE, ERR, BUSY;
    logic [5:0] CUR_COARSE, CUR_FINE;
    logic       COARSEENABLE, COARSEINC, FINEENABLE, FINEINC;
    logic       COARSEOVERFLOW = 1'b0;
    logic       FINEOVERFLOW = 1'b0;

    phaser_out_tap_ctrl #(.STEP_GAP(GAP), .COARSE_INIT(0), .FINE_INIT(0)) dut (
        .SYSCLK(SYSCLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_COARSE(REQ_COARSE), .REQ_FINE(REQ_FINE),
        .DONE(DONE), .ERR(ERR), .BUSY(BUSY),
        .CUR_COARSE(CUR_COARSE), .CUR_FINE(CUR_FINE),
        .COARSEENABLE(COARSEENABLE), .COARSEINC(COARSEINC),
        .FINEENABLE(FINEENABLE), .FINEINC(FINEINC),
        .COARSEOVERFLOW(COARSEOVERFLOW), .FINEOVERFLOW(FINEOVERFLOW)
    );

    always #5 SYSCLK = ~SYSCLK;

    // cyc names the cycle whose values are sampled at the following negedge
    int cyc = 0;
    always @(posedge SYSCLK) cyc <= cyc + 1;

    typedef struct { bit fine; bit inc; int cyc; } pulse_t;
    typedef struct { int cyc; bit err; int c; int f; } done_t;
    pulse_t pq[$];
    done_t  dq[$];

    int checks = 0;
    int errors = 0;
    int mc = 0, mf = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops an expectation whenever the DUT emits a pulse or DONE
    always @(negedge SYSCLK) begin
        if (COARSEENABLE || FINEENABLE) begin
            pulse_t p;
            checks++;
            if (COARSEENABLE && FINEENABLE) begin
                errors++;
                $display("FAIL pulse_onehot: both enables high at cycle %0d", cyc);
            end else if (pq.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: fine=%0b inc=%0b at cycle %0d", FINEENABLE,
                         FINEENABLE ? FINEINC : COARSEINC, cyc);
            end else begin
                p = pq.pop_front();
                if (FINEENABLE != p.fine || (FINEENABLE ? FINEINC : COARSEINC) != p.inc
                    || cyc != p.cyc) begin
                    errors++;
                    $display("FAIL pulse: got fine=%0b inc=%0b cyc=%0d expected fine=%0b inc=%0b cyc=%0d",
                             FINEENABLE, FINEENABLE ? FINEINC : COARSEINC, cyc, p.fine, p.inc, p.cyc);
                end
            end
        end
        if (DONE) begin
            done_t d;
            checks++;
            if (dq.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected: DONE at cycle %0d", cyc);
            end else begin
                d = dq.pop_front();
                if (cyc != d.cyc || ERR != d.err || CUR_COARSE != 6'(d.c) || CUR_FINE != 6'(d.f)) begin
                    errors++;
                    $display("FAIL done: got cyc=%0d err=%0b cur=(%0d,%0d) expected cyc=%0d err=%0b cur=(%0d,%0d)",
                             cyc, ERR, CUR_COARSE, CUR_FINE, d.cyc, d.err, d.c, d.f);
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge SYSCLK);
            if (REQ_READY) begin ok = 1; break; end
        end
        chk("ready_timeout", int'(ok), 1);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge SYSCLK);
            if (dq.size() == 0 && pq.size() == 0) begin ok = 1; break; end
        end
        chk("done_timeout", int'(ok), 1);
        repeat (3) @(negedge SYSCLK);
    endtask

    // Issues a request; pulses come from the position model, latency and final
    // position are the hand-computed vector values.
    task automatic push_walk(input int t, input int c, input int f);
        int k = 0;
        while (mc != c) begin
            pq.push_back('{fine: 0, inc: (c > mc), cyc: t + 1 + k * (GAP + 1)});
            mc = (c > mc) ? mc + 1 : mc - 1;
            k++;
        end
        while (mf != f) begin
            pq.push_back('{fine: 1, inc: (f > mf), cyc: t + 1 + k * (GAP + 1)});
            mf = (f > mf) ? mf + 1 : mf - 1;
            k++;
        end
    endtask

    task automatic request(input int c, input int f, input int lat, input int ec, input int ef);
        int t;
        wait_ready();
        t = cyc;
        REQ_VALID = 1'b1;
        REQ_COARSE = 6'(c);
        REQ_FINE = 6'(f);
        push_walk(t, c, f);
        dq.push_back('{cyc: t + lat, err: 0, c: ec, f: ef});
        mc = ec;
        mf = ef;
        @(negedge SYSCLK);
        REQ_VALID = 1'b0;
        wait_idle();
    endtask

    initial begin
        int t;
        bit busy_ok;

        repeat (3) @(negedge SYSCLK);
        RST_N = 1'b1;
        @(negedge SYSCLK);
        chk("rst_ready", int'(REQ_READY), 1);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_done", int'(DONE), 0);
        chk("rst_err", int'(ERR), 0);
        chk("rst_cur", {CUR_COARSE, CUR_FINE}, 0);
        chk("rst_en", {COARSEENABLE, COARSEINC, FINEENABLE, FINEINC}, 0);

        // T1 / T2
        request(2, 3, 46, 2, 3);
        request(0, 63, 559, 0, 63);

        // T3: equal request, overflow flags held high while idle are ignored
        COARSEOVERFLOW = 1'b1;
        FINEOVERFLOW = 1'b1;
        request(0, 63, 1, 0, 63);
        COARSEOVERFLOW = 1'b0;
        FINEOVERFLOW = 1'b0;
        chk("t3_err", int'(ERR), 0);

        // T4: fine walk 63 -> 50, overflow in 3rd gap cycle of 2nd step
        wait_ready();
        t = cyc;
        REQ_VALID = 1'b1;
        REQ_COARSE = 6'd0;
        REQ_FINE = 6'd50;
        pq.push_back('{fine: 1, inc: 0, cyc: t + 1});
        pq.push_back('{fine: 1, inc: 0, cyc: t + 10});
        dq.push_back('{cyc: t + 14, err: 1, c: 0, f: 61});
        mf = 61;
        @(negedge SYSCLK);
        REQ_VALID = 1'b0;
        while (cyc < t + 13) @(negedge SYSCLK);
        FINEOVERFLOW = 1'b1;
        @(negedge SYSCLK);
        FINEOVERFLOW = 1'b0;
        wait_idle();
        repeat (5) @(negedge SYSCLK);
        chk("t4_err_sticky", int'(ERR), 1);
        chk("t4_cur_fine", int'(CUR_FINE), 61);

        // T5: (0,61) -> (1,60) with junk held on the bus while busy, then (3,60)
        wait_ready();
        t = cyc;
        REQ_VALID = 1'b1;
        REQ_COARSE = 6'd1;
        REQ_FINE = 6'd60;
        push_walk(t, 1, 60);
        dq.push_back('{cyc: t + 19, err: 0, c: 1, f: 60});
        busy_ok = 1;
        for (int i = 1; i <= 18; i++) begin
            @(negedge SYSCLK);
            REQ_COARSE = 6'($urandom_range(0, 63));
            REQ_FINE = 6'($urandom_range(0, 63));
            if (REQ_READY) busy_ok = 0;
        end
        chk("t5_ready_low_busy", int'(busy_ok), 1);
        @(negedge SYSCLK);
        chk("t5_err_cleared", int'(ERR), 0);
        REQ_COARSE = 6'd3;
        REQ_FINE = 6'd60;
        push_walk(t + 20, 3, 60);
        dq.push_back('{cyc: t + 20 + 19, err: 0, c: 3, f: 60});
        @(negedge SYSCLK);
        chk("t5_ready_after_done", int'(REQ_READY), 1);
        @(negedge SYSCLK);
        REQ_VALID = 1'b0;
        wait_idle();

        // T6: reset during C_WAIT of walk (3,60) -> (10,60)
        wait_ready();
        t = cyc;
        REQ_VALID = 1'b1;
        REQ_COARSE = 6'd10;
        REQ_FINE = 6'd60;
        pq.push_back('{fine: 0, inc: 1, cyc: t + 1});
        @(negedge SYSCLK);
        REQ_VALID = 1'b0;
        while (cyc < t + 4) @(negedge SYSCLK);
        RST_N = 1'b0;
        @(negedge SYSCLK);
        RST_N = 1'b1;
        chk("t6_ready", int'(REQ_READY), 1);
        chk("t6_busy", int'(BUSY), 0);
        chk("t6_done", int'(DONE), 0);
        chk("t6_cur", {CUR_COARSE, CUR_FINE}, 0);
        chk("t6_en", {COARSEENABLE, FINEENABLE}, 0);
        mc = 0;
        mf = 0;
        repeat (20) @(negedge SYSCLK);

        // after reset, and coarse 0 -> 63 boundary walk
        request(0, 1, 10, 0, 1);
        request(63, 0, 577, 63, 0);

        chk("pulse_queue_empty", pq.size(), 0);
        chk("done_queue_empty", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
